tx_symbol_sequencer: RTL and testbench

Transmit-side sequencer for the CWRU transceiver. It accepts 2-bit symbols over a valid/ready handshake and encodes each one into the 8-bit pulse code used across the TX/RX path. It serialises the code MSB-first onto the transmit line at a programmable bit period, then inserts a fixed inter-symbol gap. It also holds the most recently accepted code on a parallel output that drives the seven-segment decoder, so the board display tracks the symbol on air.

---
 rtl/tx_symbol_sequencer.sv | 121 ++++++++++++
 tb/tb_tx_symbol_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_symbol_sequencer.sv
// tx_symbol_sequencer: encodes 2-bit symbols to 8-bit pulse codes and serialises them MSB-first.
// Ports: CLOCK_50, reset_n | sym_valid, sym, sym_ready | tx_out, tx_busy, code, sym_done.
module tx_symbol_sequencer #(
    parameter int CLKS_PER_BIT = 50000,
    parameter int GAP_BITS     = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       sym_valid,
    input  logic [1:0] sym,
    output logic       sym_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic [7:0] code,
    output logic       sym_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GW = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t        state, state_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    code_n;
    logic [CW-1:0] cyc, cyc_n;
    logic [2:0]    bitc, bitc_n;
    logic [GW-1:0] gapc, gapc_n;
    logic          tx_n, busy_n, done_n;

    function automatic logic [7:0] encode(input logic [1:0] s);
        encode = {1'b1, 1'b0, (s != 2'd0), 1'b0, s[1], 1'b0, (s == 2'd3), 1'b0};
    endfunction

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            shreg    <= 8'h00;
            code     <= 8'h00;
            cyc      <= '0;
            bitc     <= 3'd0;
            gapc     <= '0;
            tx_out   <= 1'b0;
            tx_busy  <= 1'b0;
            sym_done <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            code     <= code_n;
            cyc      <= cyc_n;
            bitc     <= bitc_n;
            gapc     <= gapc_n;
            tx_out   <= tx_n;
            tx_busy  <= busy_n;
            sym_done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        code_n  = code;
        cyc_n   = cyc;
        bitc_n  = bitc;
        gapc_n  = gapc;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (sym_valid) begin
                    shreg_n = encode(sym);
                    code_n  = encode(sym);
                    cyc_n   = '0;
                    bitc_n  = 3'd0;
                    gapc_n  = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cyc == CYC_LAST) begin
                    cyc_n   = '0;
                    shreg_n = {shreg[6:0], 1'b0};
                    bitc_n  = bitc + 3'd1;
                    if (bitc == 3'd7) begin
                        bitc_n  = 3'd0;
                        state_n = GAP;
                    end
                end else begin
                    cyc_n = cyc + CW'(1);
                end
            end
            GAP: begin
                if (cyc == CYC_LAST) begin
                    cyc_n = '0;
                    if (gapc == GAP_LAST) begin
                        gapc_n  = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        gapc_n = gapc + GW'(1);
                    end
                end else begin
                    cyc_n = cyc + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        // Outputs are registered from the next state so the line
        // carries bit 7 in the first cycle after the accept edge.
        tx_n   = (state_n == SHIFT) & shreg_n[7];
        busy_n = (state_n != IDLE);
    end

    assign sym_ready = (state == IDLE);

endmodule

// File: tb/tb_tx_symbol_sequencer.sv
// tb_tx_symbol_sequencer: randomized scoreboard bench for tx_symbol_sequencer.
// Ports: none (top-level bench).
module tb_tx_symbol_sequencer;

    localparam int C   = 4;
    localparam int G   = 2;
    localparam int TOT = (8 + G) * C;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       v     = 1'b0;
    logic [1:0] s     = 2'd0;
    logic       rdy, tx, busy, done;
    logic [7:0] code;
    logic       v2 = 1'b0;
    logic [1:0] s2 = 2'd0;
    logic       rdy2, tx2, busy2, done2;
    logic [7:0] code2;

    always #5 clk = ~clk;

    tx_symbol_sequencer #(.CLKS_PER_BIT(C), .GAP_BITS(G)) dut (
        .CLOCK_50(clk), .reset_n(rst_n), .sym_valid(v), .sym(s),
        .sym_ready(rdy), .tx_out(tx), .tx_busy(busy), .code(code),
        .sym_done(done)
    );

    tx_symbol_sequencer #(.CLKS_PER_BIT(2), .GAP_BITS(1)) dut2 (
        .CLOCK_50(clk), .reset_n(rst_n), .sym_valid(v2), .sym(s2),
        .sym_ready(rdy2), .tx_out(tx2), .tx_busy(busy2), .code(code2),
        .sym_done(done2)
    );

    typedef struct {
        logic [7:0] c;
        int         e;
    } exp_t;

    exp_t       q[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         ecnt       = 0;
    int         ready_at   = 0;
    bit         in_rst     = 1'b1;
    logic [7:0] exp_code   = 8'h00;

    always @(posedge clk) ecnt <= ecnt + 1;

    function automatic logic [7:0] ref_code(input int sv);
        logic [7:0] r;
        r = 8'h80;
        if (sv >= 1) r = r | 8'h20;
        if (sv >= 2) r = r | 8'h08;
        if (sv >= 3) r = r | 8'h02;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at edge %0d",
                     nm, act, exp, ecnt);
        end
    endtask

    // Monitor: compares every cycle against the transaction at the
    // head of the queue and retires it when the symbol completes.
    always @(posedge clk) begin : mon
        logic       eb, et, ed;
        logic [7:0] cc;
        int         n;
        #1;
        if (!in_rst) begin
            eb = 1'b0;
            et = 1'b0;
            ed = 1'b0;
            n  = 0;
            if (q.size() > 0 && ecnt >= q[0].e) begin
                n        = ecnt - q[0].e + 1;
                cc       = q[0].c;
                exp_code = cc;
                if (n <= 8 * C) begin
                    eb = 1'b1;
                    et = cc[7 - (n - 1) / C];
                end else if (n <= TOT) begin
                    eb = 1'b1;
                end else begin
                    ed = 1'b1;
                end
            end
            chk("tx_out", tx, et);
            chk("tx_busy", busy, eb);
            chk("sym_done", done, ed);
            chk("sym_ready", rdy, !eb);
            chk("code", code, exp_code);
            if ((done === 1'b1 || ed) && q.size() > 0 && ecnt >= q[0].e)
                void'(q.pop_front());
        end
    end

    task automatic step(input logic vv, input logic [1:0] ss, output bit acc);
        @(negedge clk);
        v   = vv;
        s   = ss;
        acc = 1'b0;
        if (vv && ecnt + 1 >= ready_at) begin
            q.push_back('{ref_code(int'(ss)), ecnt + 1});
            ready_at = ecnt + 1 + TOT + 1;
            acc      = 1'b1;
        end
    endtask

    task automatic send(input logic [1:0] ss);
        bit acc;
        int t;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 200) begin
            step(1'b1, ss, acc);
            t++;
        end
        if (!acc) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: got none expected accept of %0d", ss);
        end
    endtask

    task automatic drain();
        bit a;
        repeat (TOT + 4) step(1'b0, 2'd0, a);
    endtask

    initial begin : drv
        bit a;
        int e2, n;
        logic [7:0] aa;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tx", tx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_code", code, 0);
        chk("rst_ready", rdy, 1);
        chk("rst_code2", code2, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        ready_at = ecnt + 1;
        in_rst   = 1'b0;

        // single pulse of symbol 2
        send(2'd2);
        drain();

        // back-to-back with valid held high
        send(2'd0);
        send(2'd1);
        send(2'd3);
        drain();

        // symbol 3 toggled while busy must be ignored
        send(2'd1);
        repeat (30) step(1'($urandom_range(0, 1)), 2'd3, a);
        drain();

        // randomized traffic
        repeat (2500) step(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), a);
        drain();

        // asynchronous abort at cycle 15 of a symbol-1 transmission
        send(2'd1);
        repeat (15) step(1'b0, 2'd0, a);
        in_rst = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("abort_tx", tx, 0);
        chk("abort_busy", busy, 0);
        chk("abort_code", code, 0);
        chk("abort_done", done, 0);
        q.delete();
        exp_code = 8'h00;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        ready_at = ecnt + 1;
        in_rst   = 1'b0;
        send(2'd0);
        drain();

        // all four symbols in turn
        send(2'd0);
        send(2'd1);
        send(2'd2);
        send(2'd3);
        drain();

        // short-parameter instance: 2 clocks per bit, 1 gap bit
        @(negedge clk);
        chk("d2_ready", rdy2, 1);
        v2 = 1'b1;
        s2 = 2'd3;
        e2 = ecnt + 1;
        aa = 8'hAA;
        repeat (24) begin
            @(posedge clk);
            #1;
            v2 = 1'b0;
            n  = ecnt - e2 + 1;
            chk("d2_tx", tx2, (n <= 16) ? aa[7 - (n - 1) / 2] : 1'b0);
            chk("d2_busy", busy2, (n <= 18));
            chk("d2_done", done2, (n == 19));
            chk("d2_code", code2, 8'hAA);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
